// File: rtl/scie_pkg.sv
// Shared decode constants and mode encoding for the SCIE activation unit.
// Holds the custom opcode, the required funct7 value and the funct3 modes.
// Imported by the ALU and the pipeline wrapper.
package scie_pkg;

  // Custom-3 style opcode claimed by this unit.
  localparam logic [6:0] SCIE_OPCODE = 7'd123;

  // Only funct7 = 0 is decoded; everything else is reported illegal.
  localparam logic [6:0] SCIE_FUNCT7 = 7'd0;

  // funct3 selects the activation function; values 4..7 are illegal.
  typedef enum logic [2:0] {
    MODE_RELU  = 3'd0,
    MODE_CLAMP = 3'd1,
    MODE_SAT   = 3'd2,
    MODE_LRELU = 3'd3
  } mode_e;

endpackage

// File: rtl/scie_alu.sv
// Combinational decode and compute for RELU / CLAMP / SAT / LRELU.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the enclosing pipeline decides when results are captured.
module scie_alu
  import scie_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     insn_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [XLEN-1:0] rd_o,
  output logic            illegal_o
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] ONE = {{(XLEN-1){1'b0}}, 1'b1};

  logic signed [XLEN-1:0] a;
  logic signed [XLEN-1:0] b;
  logic signed [XLEN-1:0] relu;
  logic signed [XLEN-1:0] sat_hi;
  logic signed [XLEN-1:0] sat_lo;
  logic signed [XLEN-1:0] res;
  logic        [SHW-1:0]  sh;
  logic                   legal;
  mode_e                  mode;

  // Register-index fields of the instruction are irrelevant to the result.
  logic unused_insn_fields;
  assign unused_insn_fields = ^{insn_i[24:15], insn_i[11:7]};

  assign a    = $signed(rs1_i);
  assign b    = $signed(rs2_i);
  assign sh   = rs2_i[SHW-1:0];
  assign mode = mode_e'(insn_i[14:12]);

  // Legal only for our opcode, funct7 = 0 and funct3 in 0..3.
  assign legal = (insn_i[6:0] == SCIE_OPCODE) &&
                 (insn_i[31:25] == SCIE_FUNCT7) &&
                 (insn_i[14] == 1'b0);

  // Saturation bounds: n = sh+1 bits gives [-2^sh, 2^sh - 1]; sh = XLEN-1 is a pass-through.
  always_comb begin
    sat_hi = $signed((ONE << sh) - ONE);
    sat_lo = ~sat_hi;
  end

  // Mode select; illegal encodings force a zero result.
  always_comb begin
    relu = a[XLEN-1] ? '0 : a;
    res  = '0;
    case (mode)
      MODE_RELU:  res = relu;
      MODE_CLAMP: res = b[XLEN-1] ? '0 : ((relu > b) ? b : relu);
      MODE_SAT:   res = (a > sat_hi) ? sat_hi : ((a < sat_lo) ? sat_lo : a);
      MODE_LRELU: res = a[XLEN-1] ? (a >>> sh) : a;
      default:    res = '0;
    endcase
    if (!legal) begin
      res = '0;
    end
  end

  assign rd_o      = res;
  assign illegal_o = !legal;

endmodule

// File: rtl/scie_pipelined.sv
// Pipelined SCIE activation unit: ALU result registered through LATENCY stages with a tag and illegal flag.
// Latency: LATENCY cycles from the accepting cycle to the result on the outputs, one op per cycle sustained.
// Backpressure: each stage advances only when the one behind it empties or advances; in_ready drops once all stages are full and stalled.
module scie_pipelined
  import scie_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int LATENCY = 2,
  parameter int TAGW    = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_insn,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rd,
  output logic [TAGW-1:0] out_tag,
  output logic            out_illegal,
  output logic [31:0]     op_count
);

  logic            vld_q   [LATENCY];
  logic            vld_d   [LATENCY];
  logic [XLEN-1:0] rd_q    [LATENCY];
  logic [XLEN-1:0] rd_d    [LATENCY];
  logic [TAGW-1:0] tag_q   [LATENCY];
  logic [TAGW-1:0] tag_d   [LATENCY];
  logic            ill_q   [LATENCY];
  logic            ill_d   [LATENCY];
  logic            stage_rdy [LATENCY];
  logic            accept;
  logic            out_fire;
  logic [XLEN-1:0] alu_rd;
  logic            alu_ill;
  logic [31:0]     cnt_q;
  logic [31:0]     cnt_d;

  scie_alu #(
    .XLEN (XLEN)
  ) u_alu (
    .insn_i    (in_insn),
    .rs1_i     (in_rs1),
    .rs2_i     (in_rs2),
    .rd_o      (alu_rd),
    .illegal_o (alu_ill)
  );

  // A stage can take new contents if it, or any stage after it, has a hole, or the consumer is taking the output.
  always_comb begin : ready_chain
    logic run;
    run = out_ready;
    for (int i = LATENCY - 1; i >= 0; i--) begin
      run          = run | ~vld_q[i];
      stage_rdy[i] = run;
    end
  end

  // Nothing is accepted while reset is held low.
  assign in_ready = reset & stage_rdy[0];
  assign accept   = in_valid & in_ready;
  assign out_fire = vld_q[LATENCY-1] & out_ready;

  // Stage next-state: shift forward where the stage is free; data only moves with a valid op; flush kills everything.
  always_comb begin
    for (int i = 0; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i];
      rd_d[i]  = rd_q[i];
      tag_d[i] = tag_q[i];
      ill_d[i] = ill_q[i];
    end
    if (stage_rdy[0]) begin
      vld_d[0] = accept;
      if (accept) begin
        rd_d[0]  = alu_rd;
        tag_d[0] = in_tag;
        ill_d[0] = alu_ill;
      end
    end
    for (int i = 1; i < LATENCY; i++) begin
      if (stage_rdy[i]) begin
        vld_d[i] = vld_q[i-1];
        if (vld_q[i-1]) begin
          rd_d[i]  = rd_q[i-1];
          tag_d[i] = tag_q[i-1];
          ill_d[i] = ill_q[i-1];
        end
      end
    end
    if (flush) begin
      for (int i = 0; i < LATENCY; i++) begin
        vld_d[i] = 1'b0;
      end
    end
  end

  // Stage registers; reset clears valid and data so the outputs read zero.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        rd_q[i]  <= '0;
        tag_q[i] <= '0;
        ill_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        vld_q[i] <= vld_d[i];
        rd_q[i]  <= rd_d[i];
        tag_q[i] <= tag_d[i];
        ill_q[i] <= ill_d[i];
      end
    end
  end

  // Completed-op counter saturates at all-ones and ignores flush.
  always_comb begin
    cnt_d = cnt_q;
    if (out_fire && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_valid   = vld_q[LATENCY-1];
  assign out_rd      = rd_q[LATENCY-1];
  assign out_tag     = tag_q[LATENCY-1];
  assign out_illegal = ill_q[LATENCY-1];
  assign op_count    = cnt_q;

endmodule

// File: tb/tb_scie_pipelined.sv
// Self-checking bench for scie_pipelined: directed spec vectors plus randomized traffic
// against an arithmetic reference model and an in-order scoreboard.
module tb_scie_pipelined;

  localparam int XLEN    = 32;
  localparam int LATENCY = 2;
  localparam int TAGW    = 5;

  logic            clock     = 1'b0;
  logic            reset     = 1'b0;
  logic            flush     = 1'b0;
  logic            in_valid  = 1'b0;
  logic            out_ready = 1'b0;
  logic [31:0]     in_insn   = '0;
  logic [XLEN-1:0] in_rs1    = '0;
  logic [XLEN-1:0] in_rs2    = '0;
  logic [TAGW-1:0] in_tag    = '0;
  logic            in_ready;
  logic            out_valid;
  logic [XLEN-1:0] out_rd;
  logic [TAGW-1:0] out_tag;
  logic            out_illegal;
  logic [31:0]     op_count;

  scie_pipelined #(
    .XLEN    (XLEN),
    .LATENCY (LATENCY),
    .TAGW    (TAGW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_insn     (in_insn),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_rd      (out_rd),
    .out_tag     (out_tag),
    .out_illegal (out_illegal),
    .op_count    (op_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0]     rd;
    logic [TAGW-1:0] tag;
    logic            ill;
  } exp_t;

  exp_t        q[$];
  logic [31:0] exp_cnt = '0;

  // Reference: activation functions written as plain signed integer arithmetic.
  function automatic exp_t model(input logic [31:0] insn, input logic [31:0] a32,
                                 input logic [31:0] b32, input logic [TAGW-1:0] tag);
    exp_t   e;
    longint a, b, r, t, hi, lo, p;
    int     sh, n;
    a  = longint'($signed(a32));
    b  = longint'($signed(b32));
    sh = int'(b32[4:0]);
    n  = sh + 1;
    e.tag = tag;
    e.ill = !((insn[6:0] == 7'd123) && (insn[31:25] == 7'd0) && (insn[14:12] <= 3'd3));
    r = 0;
    if (!e.ill) begin
      case (insn[14:12])
        3'd0: r = (a < 0) ? 0 : a;
        3'd1: begin
          t = (a < 0) ? 0 : a;
          r = (b < 0) ? 0 : ((t > b) ? b : t);
        end
        3'd2: begin
          hi = (longint'(1) << (n - 1)) - 1;
          lo = -(longint'(1) << (n - 1));
          r  = (a > hi) ? hi : ((a < lo) ? lo : a);
        end
        3'd3: begin
          p = longint'(1) << sh;
          r = (a < 0) ? -((-a + p - 1) / p) : a;
        end
        default: r = 0;
      endcase
    end
    e.rd = r[31:0];
    return e;
  endfunction

  // Scoreboard: inputs are stable at the falling edge, so handshakes for the next rising edge are known here.
  always @(negedge clock) begin
    check("op_count", 64'(op_count), 64'(exp_cnt));
    if (!reset) begin
      q.delete();
      exp_cnt = '0;
    end else begin
      if (q.size() == 0) begin
        check("spurious_out", 64'(out_valid), 64'(0));
      end else if (out_valid) begin
        check("sb_rd",  64'(out_rd),      64'(q[0].rd));
        check("sb_tag", 64'(out_tag),     64'(q[0].tag));
        check("sb_ill", 64'(out_illegal), 64'(q[0].ill));
        if (out_ready) begin
          void'(q.pop_front());
          if (exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
        end
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back(model(in_insn, in_rs1, in_rs2, in_tag));
    end
  end

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
    return {f7, 5'd2, 5'd1, f3, 5'd4, op};
  endfunction

  function automatic logic [31:0] rand_insn();
    logic [2:0] f3;
    logic [6:0] op;
    logic [6:0] f7;
    int r;
    r  = int'($urandom_range(0, 19));
    f3 = 3'($urandom_range(0, 3));
    op = 7'd123;
    f7 = 7'd0;
    if (r == 0) f3 = 3'($urandom_range(4, 7));
    if (r == 1) op = 7'($urandom);
    if (r == 2) f7 = 7'($urandom_range(1, 127));
    return {f7, 10'($urandom), f3, 5'($urandom), op};
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 4))
      0: return 32'($urandom_range(0, 600)) - 32'd300;
      1: return 32'($urandom);
      2: return ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      3: return 32'($urandom_range(0, 40));
      default: return 32'($urandom_range(0, 70000)) - 32'd35000;
    endcase
  endfunction

  // Present one op and hold it until accepted; entered and left just after a rising edge.
  task automatic send(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAGW-1:0] tag);
    bit took;
    int n;
    took = 1'b0;
    n    = 0;
    in_valid = 1'b1; in_insn = insn; in_rs1 = a; in_rs2 = b; in_tag = tag;
    while (!took && n < 200) begin
      @(negedge clock);
      took = in_ready;
      @(posedge clock); #1;
      n++;
    end
    check("send_accepted", 64'(took), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 500) begin
      @(posedge clock); #1;
      n++;
    end
    check("drain_empty", 64'(q.size()), 64'(0));
  endtask

  task automatic do_reset();
    reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  // Single op with out_ready high: measures latency and checks the spec value directly.
  task automatic run_one(input string name, input logic [31:0] insn, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAGW-1:0] tag,
                         input logic [31:0] rd_exp, input logic ill_exp);
    int n;
    out_ready = 1'b1;
    in_valid = 1'b1; in_insn = insn; in_rs1 = a; in_rs2 = b; in_tag = tag;
    @(posedge clock); #1;
    in_valid = 1'b0;
    n = 1;
    @(negedge clock);
    while (!out_valid && n < 20) begin
      @(posedge clock);
      n++;
      @(negedge clock);
    end
    check({name, "_lat"}, 64'(n), 64'(LATENCY));
    check({name, "_rd"},  64'(out_rd), 64'(rd_exp));
    check({name, "_ill"}, 64'(out_illegal), 64'(ill_exp));
    check({name, "_tag"}, 64'(out_tag), 64'(tag));
    @(posedge clock); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  bit rand_rdy;
  int seen;

  initial begin
    do_reset();
    @(negedge clock);
    check("rst_in_ready",  64'(in_ready),  64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_op_count",  64'(op_count),  64'(0));
    @(posedge clock); #1;

    // Directed mode vectors.
    run_one("relu_neg",  mk(7'd0, 3'd0, 7'd123), 32'(-8704), 32'd0, 5'd1, 32'd0,      1'b0);
    run_one("relu_pos",  mk(7'd0, 3'd0, 7'd123), 32'd9472,   32'd0, 5'd2, 32'd9472,   1'b0);
    run_one("clamp",     mk(7'd0, 3'd1, 7'd123), 32'd12800,  32'd6400, 5'd3, 32'd6400, 1'b0);
    run_one("sat_pos",   mk(7'd0, 3'd2, 7'd123), 32'd300,    32'd7, 5'd4, 32'd127,    1'b0);
    run_one("sat_neg",   mk(7'd0, 3'd2, 7'd123), 32'(-300),  32'd7, 5'd5, 32'(-128),  1'b0);
    run_one("lrelu",     mk(7'd0, 3'd3, 7'd123), 32'(-4096), 32'd4, 5'd6, 32'(-256),  1'b0);
    run_one("ill_f3",    mk(7'd0, 3'd5, 7'd123), 32'd1234,   32'd3, 5'd7, 32'd0,      1'b1);
    run_one("ill_opc",   mk(7'd0, 3'd0, 7'h33),  32'd1234,   32'd3, 5'd8, 32'd0,      1'b1);
    @(negedge clock);
    check("dir_op_count", 64'(op_count), 64'(8));
    @(posedge clock); #1;

    // Backpressure: eight back-to-back ops against a stalled consumer.
    do_reset();
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          send(mk(7'd0, 3'(k % 4), 7'd123), 32'(k * 1000 - 3000), 32'(k + 2), 5'(k));
        end
      end
      begin
        repeat (4) @(posedge clock);
        @(negedge clock);
        check("bp_in_ready_low", 64'(in_ready),  64'(0));
        check("bp_out_valid",    64'(out_valid), 64'(1));
        @(posedge clock); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    @(negedge clock);
    check("bp_op_count", 64'(op_count), 64'(8));
    @(posedge clock); #1;

    // Flush with two ops in flight and a third presented in the flush cycle.
    do_reset();
    out_ready = 1'b0;
    send(mk(7'd0, 3'd0, 7'd123), 32'd11, 32'd0, 5'd11);
    send(mk(7'd0, 3'd0, 7'd123), 32'd22, 32'd0, 5'd12);
    flush = 1'b1;
    in_valid = 1'b1; in_insn = mk(7'd0, 3'd0, 7'd123); in_rs1 = 32'd33; in_tag = 5'd13;
    @(posedge clock); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    check("flush_out_valid", 64'(out_valid), 64'(0));
    @(posedge clock); #1;
    out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      seen += int'(out_valid);
    end
    check("flush_no_emit",  64'(seen),     64'(0));
    check("flush_op_count", 64'(op_count), 64'(0));
    @(posedge clock); #1;

    // Randomized traffic with a randomly stalling consumer.
    rand_rdy = 1'b1;
    fork
      begin
        for (int k = 0; k < 300; k++) begin
          send(rand_insn(), rand_val(), rand_val(), 5'(k));
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clock); #1;
          end
        end
        rand_rdy = 1'b0;
      end
      begin
        while (rand_rdy) begin
          @(posedge clock); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    // Reset asserted mid-stream while a new op is also being presented.
    out_ready = 1'b1;
    in_valid = 1'b1; in_insn = mk(7'd0, 3'd0, 7'd123); in_rs1 = 32'd100; in_rs2 = '0; in_tag = 5'd9;
    @(posedge clock); #1;
    in_rs1 = 32'd200; in_tag = 5'd10;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    check("mid_rst_out_valid", 64'(out_valid),   64'(0));
    check("mid_rst_out_rd",    64'(out_rd),      64'(0));
    check("mid_rst_out_tag",   64'(out_tag),     64'(0));
    check("mid_rst_out_ill",   64'(out_illegal), 64'(0));
    check("mid_rst_op_count",  64'(op_count),    64'(0));
    check("mid_rst_in_ready",  64'(in_ready),    64'(0));
    in_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    check("post_rst_in_ready",  64'(in_ready),  64'(1));
    check("post_rst_out_valid", 64'(out_valid), 64'(0));
    @(posedge clock); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
